// File: rtl/hash_pkg.sv
// Shared types and widths for the hash message feeder.
package hash_pkg;

    localparam int LEN_W  = 64;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FIRST     = 2'd1,
        STREAM    = 2'd2,
        WAIT_DONE = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/hash_feeder_fifo.sv
// Synchronous byte FIFO with registered read data; DEPTH must be a power of two (>= 2).
module hash_feeder_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] rdata_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = rdata_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                rdata_q  <= mem[rd_ptr_q];
            end
            // simultaneous push and pop leaves the occupancy unchanged
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hash_msg_feeder.sv
// Feeds a length-prefixed byte message to a hash core; optional msg_count via HASH_FEEDER_MSG_COUNT_EN.
//   state     | meaning
//   IDLE      | waiting for a message length
//   FIRST     | emit first byte, or a single zero byte for an empty message
//   STREAM    | emit remaining bytes as they arrive in the FIFO
//   WAIT_DONE | wait for a fresh rising edge of hash_ready
module hash_msg_feeder
    import hash_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_len_valid,
    input  logic [LEN_W-1:0]  s_len,
    output logic              s_len_ready,
    input  logic              s_byte_valid,
    input  logic [BYTE_W-1:0] s_byte,
    output logic              s_byte_ready,
    input  logic              hash_ready,
    output logic              M_valid,
    output logic [BYTE_W-1:0] M,
    output logic [LEN_W-1:0]  C_in,
`ifdef HASH_FEEDER_MSG_COUNT_EN
    output logic [31:0]       msg_count,
`endif
    output logic              busy
);

    feeder_state_e     state_q;
    logic [LEN_W-1:0]  len_r_q;
    logic [LEN_W-1:0]  remaining_q;
    logic              m_valid_q;
    logic              m_zero_q;
    logic              busy_q;
    logic              hr_q;
    logic              fifo_full, fifo_empty;
    logic [BYTE_W-1:0] fifo_rdata;
    logic              pop;
    logic              done;

    assign pop  = !fifo_empty && (remaining_q != '0) &&
                  ((state_q == FIRST) || (state_q == STREAM));
    assign done = (state_q == WAIT_DONE) && hash_ready && !hr_q;

    hash_feeder_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (s_byte_valid),
        .wdata_i (s_byte),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_r_q     <= '0;
            remaining_q <= '0;
            m_valid_q   <= 1'b0;
            m_zero_q    <= 1'b0;
            busy_q      <= 1'b0;
            hr_q        <= 1'b0;
        end else begin
            hr_q      <= hash_ready;
            m_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s_len_valid) begin
                        len_r_q     <= s_len;
                        remaining_q <= s_len;
                        busy_q      <= 1'b1;
                        state_q     <= FIRST;
                    end
                end
                FIRST: begin
                    if (len_r_q == '0) begin
                        m_valid_q <= 1'b1;
                        m_zero_q  <= 1'b1;
                        state_q   <= WAIT_DONE;
                    end else if (pop) begin
                        m_valid_q   <= 1'b1;
                        m_zero_q    <= 1'b0;
                        remaining_q <= remaining_q - LEN_W'(1);
                        state_q     <= (remaining_q == LEN_W'(1)) ? WAIT_DONE : STREAM;
                    end
                end
                STREAM: begin
                    if (pop) begin
                        m_valid_q   <= 1'b1;
                        m_zero_q    <= 1'b0;
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_q <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (done) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef HASH_FEEDER_MSG_COUNT_EN
    logic [31:0] msg_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_count_q <= '0;
        end else if (done) begin
            msg_count_q <= msg_count_q + 32'd1;
        end
    end

    assign msg_count = msg_count_q;
`endif

    // M holds the last popped byte, except after an empty message where it reads zero
    assign M            = m_zero_q ? '0 : fifo_rdata;
    assign M_valid      = m_valid_q;
    assign busy         = busy_q;
    assign C_in         = busy_q ? len_r_q : '0;
    assign s_len_ready  = (state_q == IDLE);
    assign s_byte_ready = !fifo_full;

endmodule
